hazard_tracker: RTL
===================

// Module: hazard_tracker
// PURPOSE
//  Consumer side of the per-instruction need/Tuse/Tnew timing table. It tracks the
//  destination register and remaining Tnew of every instruction in the E, M and W stages.
//  It compares these against the D-stage operand demand, then drives pipeline stall and
//  all forwarding-mux selects.
//  Sits in the CPU top level, between the D-stage timing decode and the pipeline registers.
// PARAMETERS
//  REGW   5  register-address width
//  TW     3  Tnew/Tuse width
// PORTS
//  clk        in   1     system clock, rising edge
//  reset      in   1     asynchronous, active-high; clears all stage records
//  rs_D       in   REGW  D-stage rs address
//  rt_D       in   REGW  D-stage rt address
//  need_rs    in   1     D instruction reads rs
//  need_rt    in   1     D instruction reads rt
//  Tuse_rs    in   TW    cycles after D until the rs value is consumed
//  Tuse_rt    in   TW    cycles after D until the rt value is consumed
//  Tnew_D     in   TW    cycles after E entry until the result exists
//  dst_D      in   REGW  D-stage write address (0 = no write)
//  md_use_D   in   1     D instruction is mult/div/mfhi/mflo/mthi/mtlo
//  md_busy    in   1     multiply/divide unit is busy
//  md_start   in   1     E-stage instruction is starting mult/div this cycle
//  flush      in   1     exception/eret flush; squashes D, E and M
//  stall      out  1     hold PC and F/D; insert a bubble into E
//  fwd_rs_D   out  2     D rs source: 0 = regfile, 1 = E, 2 = M, 3 = W
//  fwd_rt_D   out  2     D rt source, same encoding
//  fwd_rs_E   out  2     E rs source: 0 = from D/E register, 2 = M, 3 = W
//  fwd_rt_E   out  2     E rt source, same encoding
//  fwd_rt_M   out  2     M rt (store data / mtc0) source: 0 = pipe register, 3 = W
// BEHAVIOUR
//  Per-stage record: {dst, tnew, rs, rt}.
//   - E stores {dst, tnew, rs, rt}.
//   - M stores {dst, tnew, rt}.
//   - W stores {dst, tnew}.
//  Reset value of every field is 0, so at reset: stall = 0 and all fwd_* = 0.
//  Each clock edge, flush has priority:
//   - flush: E, M and W records all become 0.
//   - else if stall: E becomes 0 (bubble); M <= E; W <= M.
//   - else: E <= {dst_D, Tnew_D, rs_D, rt_D}; M <= E; W <= M.
//  Tnew decrement: tnew fields are decremented when advancing E->M and M->W, saturating at 0.
//   - Decrement applies in the stall case as well.
//   - Maximum loaded value is 2, so the W record always has tnew = 0.
//  Match definition:
//   - match_X(a) = (dst_X == a) && (a != 0).
//   - Register $0 never stalls and is never forwarded.
//  Stall for operand r in {rs, rt}, nearest matching stage only:
//   - If E matches: stall when need_r && tnew_E > Tuse_r.
//   - Else if M matches: stall when need_r && tnew_M > Tuse_r.
//   - W never stalls.
//  md stall = md_use_D && (md_busy || md_start).
//  stall = stall_rs | stall_rt | md stall. Combinational, no added latency.
//  Forwarding selects:
//   - fwd_*_D: first match in E, M, W whose tnew == 0 gives code 1, 2 or 3.
//     A match with tnew != 0 gives 0; stall covers that case.
//   - fwd_*_E: uses the E record's rs/rt; M (tnew == 0) beats W.
//   - fwd_rt_M: uses the M record's rt; code 3 on a W match, else 0.
//   - All selects are combinational from the current records and D inputs.
//  Boundary cases:
//   - flush during an active stall: records clear on the next edge, so stall falls unless md stall holds.
//   - reset asserted mid-operation clears everything immediately (async).
//   - need_r = 0 suppresses the stall for that operand; forwarding selects are still computed.
// TESTING
//  1. lw $1; add $2,$1,$1 -> stall = 1 for exactly 1 cycle; then fwd_rs_E = fwd_rt_E = 3.
//  2. lw $1; beq $1,$0 -> stall for 2 cycles; third cycle fwd_rs_D = 3, stall = 0.
//  3. addu $1; beq $1,$1 -> stall for 1 cycle; then fwd_rs_D = fwd_rt_D = 2.
//  4. addu $1; addu $3,$1,$0 -> no stall; next cycle fwd_rs_E = 2.
//     Repeat with dst = $0 -> all fwd_* = 0.
//  5. jal (dst 31, Tnew 0); jr $31 -> no stall, fwd_rs_D = 1.
//     lw $5; sw $5,0($0) -> no stall, later fwd_rt_M = 3.
//  6. md_busy = 1 with mflo in D -> stall held until md_busy falls.
//     Scenario-2 stall plus flush pulse -> next cycle stall = 0, all fwd_* = 0.
//     Async reset mid-sequence -> outputs drop to 0 immediately.

Source files
------------

// File: rtl/hazard_tracker_if.sv
// D-stage operand demand into the hazard tracker, and the stall/forward-select
// decisions it returns to the pipeline.
interface hazard_tracker_if #(
   parameter int REGW = 5,
   parameter int TW   = 3
) ();
   logic [REGW-1:0] rs_D;
   logic [REGW-1:0] rt_D;
   logic            need_rs;
   logic            need_rt;
   logic [TW-1:0]   Tuse_rs;
   logic [TW-1:0]   Tuse_rt;
   logic [TW-1:0]   Tnew_D;
   logic [REGW-1:0] dst_D;
   logic            md_use_D;
   logic            md_busy;
   logic            md_start;
   logic            flush;
   logic            stall;
   logic [1:0]      fwd_rs_D;
   logic [1:0]      fwd_rt_D;
   logic [1:0]      fwd_rs_E;
   logic [1:0]      fwd_rt_E;
   logic [1:0]      fwd_rt_M;

   modport master (
      output rs_D, rt_D, need_rs, need_rt, Tuse_rs, Tuse_rt, Tnew_D, dst_D,
             md_use_D, md_busy, md_start, flush,
      input  stall, fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M
   );

   modport slave (
      input  rs_D, rt_D, need_rs, need_rt, Tuse_rs, Tuse_rt, Tnew_D, dst_D,
             md_use_D, md_busy, md_start, flush,
      output stall, fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M
   );
endinterface

// File: rtl/hazard_tracker.sv
// Tracks destination/Tnew of the E, M and W instructions and resolves D-stage
// operand demand into a pipeline stall and the forwarding-mux selects.
module hazard_tracker #(
   parameter int REGW = 5,
   parameter int TW   = 3
) (
   input logic             clk,
   input logic             reset,
   hazard_tracker_if.slave bus
);

   logic [REGW-1:0] r_e_dst;
   logic [TW-1:0]   r_e_tnew;
   logic [REGW-1:0] r_e_rs;
   logic [REGW-1:0] r_e_rt;
   logic [REGW-1:0] r_m_dst;
   logic [TW-1:0]   r_m_tnew;
   logic [REGW-1:0] r_m_rt;
   logic [REGW-1:0] r_w_dst;
   logic [TW-1:0]   r_w_tnew;

   logic w_stall_rs;
   logic w_stall_rt;
   logic w_md_stall;
   logic w_stall;

   function automatic logic f_match(input logic [REGW-1:0] dst, input logic [REGW-1:0] a);
      return (dst == a) && (a != {REGW{1'b0}});
   endfunction

   function automatic logic [TW-1:0] f_dec(input logic [TW-1:0] t);
      return (t == {TW{1'b0}}) ? {TW{1'b0}} : t - {{(TW-1){1'b0}}, 1'b1};
   endfunction

   // Only the nearest producer matters; W results are always available.
   function automatic logic f_stall(
      input logic [REGW-1:0] e_dst, input logic [TW-1:0] e_tnew,
      input logic [REGW-1:0] m_dst, input logic [TW-1:0] m_tnew,
      input logic [REGW-1:0] a, input logic need, input logic [TW-1:0] tuse);
      logic s;
      if (f_match(e_dst, a)) begin
         s = need && (e_tnew > tuse);
      end else if (f_match(m_dst, a)) begin
         s = need && (m_tnew > tuse);
      end else begin
         s = 1'b0;
      end
      return s;
   endfunction

   function automatic logic [1:0] f_fwd(
      input logic [REGW-1:0] e_dst, input logic [TW-1:0] e_tnew,
      input logic [REGW-1:0] m_dst, input logic [TW-1:0] m_tnew,
      input logic [REGW-1:0] w_dst, input logic [TW-1:0] w_tnew,
      input logic [REGW-1:0] a);
      logic [1:0] c;
      if (f_match(e_dst, a)) begin
         c = (e_tnew == {TW{1'b0}}) ? 2'd1 : 2'd0;
      end else if (f_match(m_dst, a)) begin
         c = (m_tnew == {TW{1'b0}}) ? 2'd2 : 2'd0;
      end else if (f_match(w_dst, a)) begin
         c = (w_tnew == {TW{1'b0}}) ? 2'd3 : 2'd0;
      end else begin
         c = 2'd0;
      end
      return c;
   endfunction

   // stall decision from the current records and D-stage demand
   always_comb begin
      w_stall_rs = f_stall(r_e_dst, r_e_tnew, r_m_dst, r_m_tnew,
                           bus.rs_D, bus.need_rs, bus.Tuse_rs);
      w_stall_rt = f_stall(r_e_dst, r_e_tnew, r_m_dst, r_m_tnew,
                           bus.rt_D, bus.need_rt, bus.Tuse_rt);
      w_md_stall = bus.md_use_D && (bus.md_busy || bus.md_start);
      w_stall    = w_stall_rs || w_stall_rt || w_md_stall;
   end

   // E/M/W records advance each edge; flush squashes all, stall bubbles E
   always_ff @(posedge clk or posedge reset) begin
      if (reset || bus.flush) begin
         r_e_dst  <= {REGW{1'b0}};
         r_e_tnew <= {TW{1'b0}};
         r_e_rs   <= {REGW{1'b0}};
         r_e_rt   <= {REGW{1'b0}};
         r_m_dst  <= {REGW{1'b0}};
         r_m_tnew <= {TW{1'b0}};
         r_m_rt   <= {REGW{1'b0}};
         r_w_dst  <= {REGW{1'b0}};
         r_w_tnew <= {TW{1'b0}};
      end else begin
         if (w_stall) begin
            r_e_dst  <= {REGW{1'b0}};
            r_e_tnew <= {TW{1'b0}};
            r_e_rs   <= {REGW{1'b0}};
            r_e_rt   <= {REGW{1'b0}};
         end else begin
            r_e_dst  <= bus.dst_D;
            r_e_tnew <= bus.Tnew_D;
            r_e_rs   <= bus.rs_D;
            r_e_rt   <= bus.rt_D;
         end
         r_m_dst  <= r_e_dst;
         r_m_tnew <= f_dec(r_e_tnew);
         r_m_rt   <= r_e_rt;
         r_w_dst  <= r_m_dst;
         r_w_tnew <= f_dec(r_m_tnew);
      end
   end

   // Later-stage selects reuse the D resolver with the nearer stages masked off.
   assign bus.stall    = w_stall;
   assign bus.fwd_rs_D = f_fwd(r_e_dst, r_e_tnew, r_m_dst, r_m_tnew, r_w_dst, r_w_tnew, bus.rs_D);
   assign bus.fwd_rt_D = f_fwd(r_e_dst, r_e_tnew, r_m_dst, r_m_tnew, r_w_dst, r_w_tnew, bus.rt_D);
   assign bus.fwd_rs_E = f_fwd({REGW{1'b0}}, {TW{1'b0}}, r_m_dst, r_m_tnew, r_w_dst, r_w_tnew, r_e_rs);
   assign bus.fwd_rt_E = f_fwd({REGW{1'b0}}, {TW{1'b0}}, r_m_dst, r_m_tnew, r_w_dst, r_w_tnew, r_e_rt);
   assign bus.fwd_rt_M = f_fwd({REGW{1'b0}}, {TW{1'b0}}, {REGW{1'b0}}, {TW{1'b0}},
                               r_w_dst, r_w_tnew, r_m_rt);

endmodule
